// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/rvalid handshake,
// holds each instruction until acknowledged, and traps on misaligned targets.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic        funct7bit5,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        instr_ack,
  input  logic        PCSrc,
  input  logic        jalr,
  input  logic [31:0] pc_target,
  input  logic [31:0] alu_result,
  output logic        trap,
  output logic [31:0] trap_addr,
  output logic [31:0] retired
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    TRAP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        trap_q, trap_d;
  logic [31:0] trap_addr_q, trap_addr_d;
  logic [31:0] retired_q, retired_d;

  logic [31:0] seq_pc;
  logic [31:0] redirect_pc;
  logic [31:0] next_pc;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      instr_q     <= NOP;
      trap_q      <= 1'b0;
      trap_addr_q <= '0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      trap_q      <= trap_d;
      trap_addr_q <= trap_addr_d;
      retired_q   <= retired_d;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    seq_pc      = pc_q + 32'd4;
    // jalr target has its LSB forced to zero before the alignment check
    redirect_pc = jalr ? (alu_result & 32'hFFFF_FFFE) : pc_target;
    next_pc     = PCSrc ? redirect_pc : seq_pc;

    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    trap_d      = trap_q;
    trap_addr_d = trap_addr_q;
    retired_d   = retired_q;

    case (state_q)
      FETCH: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (instr_ack) begin
          retired_d = retired_q + 32'd1;
          if (next_pc[1:0] == 2'b00) begin
            pc_d    = next_pc;
            state_d = FETCH;
          end else begin
            trap_d      = 1'b1;
            trap_addr_d = next_pc;
            state_d     = TRAP;
          end
        end
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Output logic
  always_comb begin
    imem_req    = (state_q == FETCH);
    imem_addr   = pc_q;
    instr_valid = (state_q == HOLD);
    instr       = instr_q;
    opcode      = instr_q[6:0];
    funct3      = instr_q[14:12];
    funct7bit5  = instr_q[30];
    pc          = pc_q;
    pc_plus4    = pc_q + 32'd4;
    trap        = trap_q;
    trap_addr   = trap_addr_q;
    retired     = retired_q;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that sits directly upstream of the core's controller and datapath. It owns the program counter and fetches instruction words over a valid/ready-style memory handshake. It presents each instruction, with its decoded opcode/funct3/funct7bit5 fields, until the execute side acknowledges it. On acknowledge it takes the next PC from the controller's PCSrc/jalr outputs and the datapath's target values, and traps on misaligned targets.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset (must be word-aligned)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request; held high with stable imem_addr until imem_rvalid
- imem_addr  out  32  byte address of word being fetched (= pc)
- imem_rvalid  in  1  instruction word valid this cycle (may be same cycle as imem_req)
- imem_rdata  in  32  instruction word
- instr  out  32  held instruction
- instr_valid  out  1  instr/pc/fields valid, awaiting instr_ack
- opcode  out  7  instr[6:0]
- funct3  out  3  instr[14:12]
- funct7bit5  out  1  instr[30]
- pc  out  32  address of held instruction
- pc_plus4  out  32  pc + 4, modulo 2^32
- instr_ack  in  1  execute side has retired the held instruction (sampled only when instr_valid)
- PCSrc  in  1  redirect (branch taken or jump)
- jalr  in  1  redirect target is ALU result (jalr)
- pc_target  in  32  pc + immediate from the datapath
- alu_result  in  32  ALU result from the datapath (jalr target before LSB clear)
- trap  out  1  misaligned-target trap; sticky until reset
- trap_addr  out  32  offending target address
- retired  out  32  count of acknowledged instructions, wraps at 2^32

## Operation
- States: FETCH, HOLD, TRAP. Reset enters FETCH with pc=RESET_PC, instr=32'h0000_0013 (nop), instr_valid=0, trap=0, trap_addr=0, retired=0.
- FETCH: imem_req=1, imem_addr=pc. If imem_rvalid=1, register imem_rdata into instr and go to HOLD.
- HOLD: instr_valid=1, imem_req=0. If instr_ack=0, stay in HOLD with all outputs stable. If instr_ack=1:
  - retired increments.
  - next = PCSrc ? (jalr ? {alu_result[31:1],1'b0} : pc_target) : pc_plus4.
  - jalr is ignored when PCSrc=0.
  - If next[1:0]==2'b00: pc<=next and go to FETCH.
  - Otherwise: trap<=1, trap_addr<=next, pc unchanged, go to TRAP.
- TRAP: imem_req=0, instr_valid=0. Stays in TRAP until reset.
- imem_rvalid is ignored outside FETCH. instr_ack is ignored outside HOLD.
- opcode, funct3 and funct7bit5 are combinational slices of the instr register. pc_plus4 is combinational from pc.
- Instruction memory resets with this block. No response to a pre-reset request may arrive after reset deasserts.

## Timing
- imem_req is combinational from state, so it is asserted in the first cycle after reset deasserts.
- With a zero-latency memory (rvalid in the same cycle as req) and immediate ack, each instruction takes 2 cycles: FETCH then HOLD.
- An N-cycle memory adds N cycles in FETCH. imem_addr is stable for the whole request.
- instr and instr_valid update on the clock edge after rvalid is sampled. pc updates on the edge after the ack.
- Wrap-around: pc=32'hFFFF_FFFC with no redirect gives next pc = 0 (aligned, no trap).
- Reset in any state, including mid-FETCH with rvalid high in the same cycle, wins. That response is discarded and all outputs return to their reset values.

## Test plan
- Sequential fetch, zero-latency memory, ack every HOLD: pc goes 0, 4, 8, 12. instr_valid is high every second cycle. retired=4 after 4 acks.
- Memory latency 3 with ack delayed 2 cycles: imem_addr is stable for 3 cycles, instr is stable in HOLD, only one retired increment per instruction.
- Branch: pc=0x10, PCSrc=1, jalr=0, pc_target=0x40 gives next imem_addr=0x40. jalr with alu_result=0x81 gives 0x80, no trap.
- Misaligned: PCSrc=1, jalr=0, pc_target=0x42 gives trap=1, trap_addr=0x42, imem_req=0 forever, instr_valid=0. The following reset clears trap.
- Boundary: RESET_PC=32'hFFFF_FFFC, ack with PCSrc=0 gives pc=0. PCSrc=0 with jalr=1 still gives pc+4.
- Reset asserted in FETCH while imem_rvalid=1: afterwards instr_valid=0, pc=RESET_PC, retired=0, and a fresh fetch starts the next cycle.
